stereo_wr_arb: RTL and testbench
================================

STEREO_WR_ARB -- requirements
Module: stereo_wr_arb

Interface
REQ-001 The block SHALL have parameter PIX, default 10000, pixels per eye frame (100x100).
REQ-002 The block SHALL have parameter AW, default 16, write-address width.
REQ-003 The block SHALL have parameter DW, default 3, pixel width.
REQ-004 vclk  in  1  sole clock; all logic on posedge vclk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 capture  in  1  one-cycle request to grab one stereo frame.
REQ-007 vblank  in  1  display vertical-blank level; high = safe to overwrite buffers.
REQ-008 validl / validr  in  1 each  left/right camera pixel valid.
REQ-009 datal / datar  in  DW each  left/right camera pixel.
REQ-010 readyl / readyr  out  1 each  pixel accepted when valid and ready are both high.
REQ-011 wraddr  out  AW  shared write address to both eye RAMs.
REQ-012 wrdata  out  DW  shared write data.
REQ-013 wrenl / wrenr  out  1 each  write enable for left/right RAM; never both high.
REQ-014 busy  out  1  high in ARMED and FILL.
REQ-015 done  out  1  one-cycle pulse when both eye frames are fully written.

Function
REQ-016 FSM states SHALL be IDLE, ARMED, FILL, DONE.
REQ-017 IDLE->ARMED on capture=1; capture SHALL be ignored in every other state.
REQ-018 ARMED->FILL on a vblank rising edge (registered vblank 0, current vblank 1) sampled while in ARMED; a vblank already high on entry SHALL NOT count.
REQ-019 FILL->DONE in the cycle both per-eye counters have completed; DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-020 Each eye SHALL have a counter 0..PIX-1 and a complete flag; a transfer writes at the counter value, then increments; the transfer at PIX-1 sets complete and the counter holds at PIX-1 (no wrap).
REQ-021 readyl/readyr SHALL be 0 outside FILL and 0 for an eye that is complete.
REQ-022 Arbitration SHALL be round-robin: with exactly one eligible eye valid, that eye gets ready; with both valid, the eye not granted last gets ready; the last-grant pointer SHALL reset to right, so left wins the first tie.
REQ-023 Ready SHALL be combinational from valid, state, complete flags and pointer; at most one of readyl/readyr high per cycle.
REQ-024 Write latency SHALL be 1: a transfer in cycle N yields wren(side)=1, wraddr=counter, wrdata=pixel registered at cycle N+1; otherwise wrenl=wrenr=0 and wraddr/wrdata hold.
REQ-025 The final transfer's write SHALL appear in the DONE cycle.
REQ-026 Counters and complete flags SHALL clear on entry to FILL.
REQ-027 vblank falling during FILL SHALL NOT stall or abort the fill.

Reset
REQ-028 rst=1 at any cycle, including mid-FILL, SHALL force IDLE, counters 0, complete flags 0, pointer=right, registered vblank 0, wraddr=0, wrdata=0, wrenl=wrenr=0, done=0; busy and ready SHALL be 0 by the same clock edge.
REQ-029 A partially written frame SHALL not be resumed after reset; the next capture restarts at address 0.

Structure
REQ-030 State encoding (IDLE/ARMED/FILL/DONE) and the PIX default SHALL live in a shared package with the display timing constants.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arb2 (2 requests, pointer, 2 grants).

Verification
REQ-032 capture, vblank rising, left only valid for 10000 cycles -> wraddr 0..9999 on wrenl, wrenr never 1, no done until right completes.
REQ-033 Both valid continuously -> grants alternate L,R,L,R starting L; done one cycle after 20000th transfer; total 20000 write cycles.
REQ-034 capture with vblank already high -> stays ARMED until vblank drops and rises again.
REQ-035 rst asserted at left address 5000 -> next cycle IDLE, all outputs 0; new capture writes from address 0.
REQ-036 Left complete, right still valid -> readyl=0, right gets every cycle; extra left valids never written.
REQ-037 capture pulsed during FILL -> no effect; exactly one done per frame.

Source files
------------

// File: rtl/stereo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stereo_wr_arb_pkg
// Purpose  : Shared types and constants for the stereo frame-capture writer:
//            FSM state encoding, arbitration side encoding, display timing
//            constants and the per-eye frame size derived from them.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stereo_wr_arb_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Identifies which eye received the most recent grant.
  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  // Display timing: each eye is a 100x100 active image.
  localparam int unsigned H_ACTIVE    = 100;
  localparam int unsigned V_ACTIVE    = 100;
  localparam int unsigned PIX_DEFAULT = H_ACTIVE * V_ACTIVE;

endpackage : stereo_wr_arb_pkg
`default_nettype wire

// File: rtl/stereo_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : stereo_wr_arb_if
// Purpose  : Bundles the capture control, the two camera pixel streams and the
//            shared eye-RAM write port of the stereo writer.
// Ports    : master - camera/control side (drives capture, vblank, pixels)
//            slave  - writer side (drives ready, RAM write port, status)
// Revision : 1.0 - initial release
// ============================================================================
interface stereo_wr_arb_if #(
  parameter int AW = 16,
  parameter int DW = 3
);

  logic          capture;
  logic          vblank;
  logic          validl;
  logic          validr;
  logic [DW-1:0] datal;
  logic [DW-1:0] datar;
  logic          readyl;
  logic          readyr;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic          wrenl;
  logic          wrenr;
  logic          busy;
  logic          done;

  modport master (
    output capture, vblank, validl, validr, datal, datar,
    input  readyl, readyr, wraddr, wrdata, wrenl, wrenr, busy, done
  );

  modport slave (
    input  capture, vblank, validl, validr, datal, datar,
    output readyl, readyr, wraddr, wrdata, wrenl, wrenr, busy, done
  );

endinterface : stereo_wr_arb_if
`default_nettype wire

// File: rtl/stereo_wr_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-request round-robin grant logic (purely combinational).
//            A lone request is always granted; on a tie the side that was not
//            granted last wins.
// Ports    : req_l_i / req_r_i - left/right requests
//            last_i            - side granted most recently
//            gnt_l_o / gnt_r_o - one-hot (or zero) grants
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import stereo_wr_arb_pkg::*;
(
  input  logic  req_l_i,
  input  logic  req_r_i,
  input  side_t last_i,
  output logic  gnt_l_o,
  output logic  gnt_r_o
);

  assign gnt_l_o = req_l_i & (~req_r_i | (last_i == SIDE_R));
  assign gnt_r_o = req_r_i & (~req_l_i | (last_i == SIDE_L));

endmodule : rr_arb2
`default_nettype wire

// File: rtl/stereo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : stereo_wr_arb
// Purpose  : Captures one stereo frame on request. After capture, waits for a
//            fresh vblank rising edge, then accepts left/right camera pixels
//            with round-robin arbitration and writes them to two eye RAMs
//            through a shared address/data port (one-cycle write latency).
// Ports    : vclk - clock, rst - synchronous active-high reset
//            bus  - stereo_wr_arb_if.slave (capture, vblank, pixel streams,
//                   ready, RAM write port, busy, done)
// Revision : 1.0 - initial release
// ============================================================================
module stereo_wr_arb
  import stereo_wr_arb_pkg::*;
#(
  parameter int PIX = PIX_DEFAULT,
  parameter int AW  = 16,
  parameter int DW  = 3
) (
  input  logic                 vclk,
  input  logic                 rst,
  stereo_wr_arb_if.slave       bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(PIX - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  state_t        state_q, state_d;
  logic          vblank_q;
  logic [AW-1:0] cnt_l_q, cnt_r_q;
  logic          cmp_l_q, cmp_r_q;
  side_t         last_q;
  logic [AW-1:0] wraddr_q;
  logic [DW-1:0] wrdata_q;
  logic          wrenl_q, wrenr_q;

  logic          fill;
  logic          req_l, req_r;
  logic          gnt_l, gnt_r;
  logic          last_xfer_l, last_xfer_r;
  logic          vb_rise;
  logic          fill_entry;

  // ---------------------------------------------------------------------------
  // Arbitration: only eyes still missing pixels may request, and only in FILL.
  // A grant doubles as the transfer strobe because a request already implies
  // valid.
  // ---------------------------------------------------------------------------
  assign fill  = (state_q == ST_FILL);
  assign req_l = bus.validl & fill & ~cmp_l_q;
  assign req_r = bus.validr & fill & ~cmp_r_q;

  rr_arb2 u_arb (
    .req_l_i (req_l),
    .req_r_i (req_r),
    .last_i  (last_q),
    .gnt_l_o (gnt_l),
    .gnt_r_o (gnt_r)
  );

  assign last_xfer_l = gnt_l & (cnt_l_q == LAST_ADDR);
  assign last_xfer_r = gnt_r & (cnt_r_q == LAST_ADDR);

  // A vblank that is already high when ARMED is entered is not an edge,
  // because vblank_q tracks the input every cycle regardless of state.
  assign vb_rise    = bus.vblank & ~vblank_q;
  assign fill_entry = (state_q == ST_ARMED) & (state_d == ST_FILL);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.capture) state_d = ST_ARMED;
      ST_ARMED: if (vb_rise)     state_d = ST_FILL;
      // Leave FILL in the same cycle the last outstanding pixel transfers, so
      // its write (one cycle later) lands in the DONE cycle.
      ST_FILL:  if ((cmp_l_q | last_xfer_l) & (cmp_r_q | last_xfer_r))
                  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vblank_q <= bus.vblank;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-eye address counters, completion flags and last-grant pointer.
  // Counters hold at PIX-1 once the final pixel of that eye is taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge vclk) begin
    if (rst) begin
      cnt_l_q <= '0;
      cnt_r_q <= '0;
      cmp_l_q <= 1'b0;
      cmp_r_q <= 1'b0;
      last_q  <= SIDE_R;
    end else if (fill_entry) begin
      cnt_l_q <= '0;
      cnt_r_q <= '0;
      cmp_l_q <= 1'b0;
      cmp_r_q <= 1'b0;
    end else begin
      if (gnt_l) begin
        if (last_xfer_l) cmp_l_q <= 1'b1;
        else             cnt_l_q <= cnt_l_q + ONE;
      end
      if (gnt_r) begin
        if (last_xfer_r) cmp_r_q <= 1'b1;
        else             cnt_r_q <= cnt_r_q + ONE;
      end
      if (gnt_l)      last_q <= SIDE_L;
      else if (gnt_r) last_q <= SIDE_R;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM write port. Address/data hold when nothing is written.
  // ---------------------------------------------------------------------------
  always_ff @(posedge vclk) begin
    if (rst) begin
      wraddr_q <= '0;
      wrdata_q <= '0;
      wrenl_q  <= 1'b0;
      wrenr_q  <= 1'b0;
    end else begin
      wrenl_q <= gnt_l;
      wrenr_q <= gnt_r;
      if (gnt_l) begin
        wraddr_q <= cnt_l_q;
        wrdata_q <= bus.datal;
      end else if (gnt_r) begin
        wraddr_q <= cnt_r_q;
        wrdata_q <= bus.datar;
      end
    end
  end

  assign bus.readyl = gnt_l;
  assign bus.readyr = gnt_r;
  assign bus.wraddr = wraddr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wrenl  = wrenl_q;
  assign bus.wrenr  = wrenr_q;
  assign bus.busy   = (state_q == ST_ARMED) | (state_q == ST_FILL);
  assign bus.done   = (state_q == ST_DONE);

endmodule : stereo_wr_arb
`default_nettype wire

// File: tb/tb_stereo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stereo_wr_arb
// Purpose  : Self-checking bench for stereo_wr_arb. A short table of per-cycle
//            vectors covers reset, arming, vblank edge qualification and the
//            first arbitrated writes; longer hand-written sequences cover whole
//            frames, a completed eye, and reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stereo_wr_arb;

  localparam int AW  = 16;
  localparam int DW  = 3;
  localparam int PIX = 10000;

  typedef logic [24:0] obs_t;  // {rl, rr, busy, done, wl, wr, wraddr, wrdata}

  typedef struct {
    logic    rst;
    logic    cap;
    logic    vb;
    logic    vl;
    logic    vr;
    logic [2:0] dl;
    logic [2:0] dr;
    obs_t    exp;
  } vec_t;

  logic vclk = 1'b0;
  logic rst  = 1'b1;
  always #5 vclk = ~vclk;

  stereo_wr_arb_if #(.AW(AW), .DW(DW)) ifc ();

  stereo_wr_arb #(.PIX(PIX), .AW(AW), .DW(DW)) dut (
    .vclk (vclk),
    .rst  (rst),
    .bus  (ifc)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_wa = '0;
  logic [DW-1:0] exp_wd = '0;
  vec_t tbl[16];

  function automatic obs_t pk(input logic rl, input logic rr, input logic bz,
                              input logic dn, input logic wl, input logic wr,
                              input logic [15:0] wa, input logic [2:0] wd);
    return {rl, rr, bz, dn, wl, wr, wa, wd};
  endfunction

  function automatic obs_t got();
    return {ifc.readyl, ifc.readyr, ifc.busy, ifc.done,
            ifc.wrenl, ifc.wrenr, ifc.wraddr, ifc.wrdata};
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h  {rl,rr,busy,done,wl,wr,wa[15:0],wd[2:0]} at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and check outputs before the
  // next rising edge.
  task automatic step(input logic r, input logic c, input logic vb,
                      input logic vl, input logic vr,
                      input logic [2:0] dl, input logic [2:0] dr,
                      input obs_t exp, input string nm);
    @(negedge vclk);
    rst         = r;
    ifc.capture = c;
    ifc.vblank  = vb;
    ifc.validl  = vl;
    ifc.validr  = vr;
    ifc.datal   = dl;
    ifc.datar   = dr;
    #1;
    chk(nm, got(), exp);
  endtask

  // capture with vblank low, then a vblank rising edge: FILL from next cycle.
  task automatic start_frame(input string nm);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_wa, exp_wd), {nm, "_cap"});
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_wa, exp_wd), {nm, "_armed"});
  endtask

  initial begin
    int wr_cnt;
    int dn_cnt;
    int wrr_cnt;
    logic [2:0] dl, dr;
    logic wl, wr;

    ifc.capture = 1'b0;
    ifc.vblank  = 1'b0;
    ifc.validl  = 1'b0;
    ifc.validr  = 1'b0;
    ifc.datal   = '0;
    ifc.datar   = '0;

    //            rst   cap   vb    vl    vr    dl    dr     rl    rr    busy  done  wl    wr    wa      wd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    // capture while vblank is already high: armed but no edge yet
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    // FILL: tie goes left first, then alternates; vblank falls mid-fill
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd4, pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 3'd1)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 3'd4)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 3'd7, pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 3'd5)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 3'd7)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 3'd7)};
    // reset in the middle of a frame
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 3'd7)};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0)};

    for (int k = 0; k < 16; k++) begin
      step(tbl[k].rst, tbl[k].cap, tbl[k].vb, tbl[k].vl, tbl[k].vr,
           tbl[k].dl, tbl[k].dr, tbl[k].exp, $sformatf("tbl[%0d]", k));
    end
    exp_wa = '0;
    exp_wd = '0;

    // ---- Frame A: both eyes valid every cycle -> strict L,R alternation ----
    start_frame("A");
    wr_cnt = 0;
    dn_cnt = 0;
    for (int i = 0; i < 2 * PIX; i++) begin
      dl = 3'(i);
      dr = ~3'(i);
      wl = 1'b0;
      wr = 1'b0;
      if (i > 0) begin
        exp_wa = AW'((i - 1) / 2);
        if (((i - 1) % 2) == 0) begin
          wl = 1'b1;
          exp_wd = 3'(i - 1);
        end else begin
          wr = 1'b1;
          exp_wd = ~3'(i - 1);
        end
      end
      step(1'b0, (i == 100), (i < 50), 1'b1, 1'b1, dl, dr,
           pk((i % 2) == 0, (i % 2) == 1, 1'b1, 1'b0, wl, wr, exp_wa, exp_wd), "A_fill");
      wr_cnt += int'(ifc.wrenl) + int'(ifc.wrenr);
      dn_cnt += int'(ifc.done);
    end
    exp_wa = AW'(PIX - 1);
    exp_wd = ~3'(2 * PIX - 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, exp_wa, exp_wd), "A_done");
    wr_cnt += int'(ifc.wrenl) + int'(ifc.wrenr);
    dn_cnt += int'(ifc.done);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0,
           pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_wa, exp_wd), "A_idle");
      dn_cnt += int'(ifc.done);
    end
    chk("A_write_total", obs_t'(wr_cnt), obs_t'(2 * PIX));
    chk("A_done_count", obs_t'(dn_cnt), obs_t'(1));

    // ---- Frame B: left alone, then left complete while right streams ----
    start_frame("B");
    wrr_cnt = 0;
    dn_cnt  = 0;
    for (int i = 0; i < PIX; i++) begin
      dl = 3'(i * 3);
      wl = (i > 0);
      if (i > 0) begin
        exp_wa = AW'(i - 1);
        exp_wd = 3'((i - 1) * 3);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, dl, 3'd0,
           pk(1'b1, 1'b0, 1'b1, 1'b0, wl, 1'b0, exp_wa, exp_wd), "B_left");
      wrr_cnt += int'(ifc.wrenr);
      dn_cnt  += int'(ifc.done);
    end
    chk("B_no_right_write", obs_t'(wrr_cnt), obs_t'(0));
    chk("B_no_early_done", obs_t'(dn_cnt), obs_t'(0));
    for (int j = 0; j < PIX; j++) begin
      dr = 3'(j + 2);
      if (j == 0) begin
        wl = 1'b1;
        wr = 1'b0;
        exp_wa = AW'(PIX - 1);
        exp_wd = 3'((PIX - 1) * 3);
      end else begin
        wl = 1'b0;
        wr = 1'b1;
        exp_wa = AW'(j - 1);
        exp_wd = 3'(j + 1);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, dr,
           pk(1'b0, 1'b1, 1'b1, 1'b0, wl, wr, exp_wa, exp_wd), "B_right");
    end
    exp_wa = AW'(PIX - 1);
    exp_wd = 3'(PIX - 1 + 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, exp_wa, exp_wd), "B_done");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_wa, exp_wd), "B_idle");

    // ---- Frame D: reset at left address 5000, then restart from 0 ----
    start_frame("D");
    for (int i = 0; i <= 5000; i++) begin
      dl = 3'(i + 1);
      wl = (i > 0);
      if (i > 0) begin
        exp_wa = AW'(i - 1);
        exp_wd = 3'(i);
      end
      step((i == 5000), 1'b0, 1'b1, 1'b1, 1'b0, dl, 3'd0,
           pk(1'b1, 1'b0, 1'b1, 1'b0, wl, 1'b0, exp_wa, exp_wd), "D_left");
    end
    exp_wa = '0;
    exp_wd = '0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0), "D_after_rst");
    start_frame("D2");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 3'd6,
         pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0), "D2_c0");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2,
         pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 3'd5), "D2_c1");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 3'd4,
         pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 3'd2), "D2_c2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 3'd3), "D2_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0), "D2_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_stereo_wr_arb
`default_nettype wire
